spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Byte-oriented SPI mode 0 initiator: drives sck/mosi/cs and samples miso. It is the host-side counterpart of the design's SPI slave.
- cs is active-HIGH, the same polarity the slave expects.
- Sits between an internal command/DMA engine (valid/ready byte interface) and the off-chip or on-fabric SPI link.
- Supports multi-byte transactions with cs held across bytes, and programmable sck rate and cs setup/idle timing.

Parameters:
- CLK_DIV, 2, sck half-period in clk cycles (>=1); sck freq = f_clk/(2*CLK_DIV).
- CS_SETUP, 2, clk cycles from cs rising to first sck rising edge (>=1).
- BYTE_GAP, 4, minimum clk cycles sck stays low between bytes of one transaction (>=1); lets the slave resynchronise its byte strobe.
- CS_IDLE, 2, minimum clk cycles cs stays low after a transaction before the next may start (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tx_data  in  8  byte to send, MSB first.
- tx_valid  in  1  tx_data valid; consumed on a cycle where tx_valid & tx_ready.
- tx_ready  out  1  block can accept a byte this cycle.
- keep_cs  in  1  after the current byte, hold cs and wait for a further byte instead of ending the transaction.
- rx_data  out  8  last received byte; stable until the next byte completes.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high in every state except IDLE.
- sck  out  1  SPI clock; idles low.
- mosi  out  1  serial out; changes only while sck is low.
- miso  in  1  serial in.
- cs  out  1  chip select, active-high.

Behaviour:
- Reset (async, any state): state=IDLE; sck=0, cs=0, mosi=0, rx_data=8'h00, rx_valid=0, busy=0; shift registers, bit counter and timer cleared. tx_ready=1 as soon as rst deasserts.
- Registered outputs: sck, cs, mosi, rx_data and rx_valid are all registers. tx_ready and busy are decoded from state/timer.
- One down-counting timer is shared by all timed states. Its width is clog2 of max(CLK_DIV, CS_SETUP, BYTE_GAP, CS_IDLE) + 1.
- IDLE: tx_ready=1. On accept:
  - load tx shift register with tx_data.
  - cs<=1, mosi<=tx_data[7], bit count=0.
  - go to SETUP with timer=CS_SETUP.
- SETUP: sck=0. When the timer expires:
  - sck<=1.
  - capture miso into the rx shift register LSB in that same clk cycle (the value present before the rising edge).
  - go to HIGH with timer=CLK_DIV.
- HIGH: on expiry, sck<=0.
  - If bit count <7: shift tx, drive mosi with the next bit, increment bit count, go to LOW with timer=CLK_DIV.
  - If bit count ==7: rx_data<=assembled byte, rx_valid<=1 for one cycle, go to GAP with timer=BYTE_GAP.
- LOW: on expiry, sck<=1, sample miso into the rx shift register, go to HIGH with timer=CLK_DIV.
- GAP: sck=0, cs=1, tx_ready=0 until the timer expires. After expiry:
  - tx_ready=1.
  - If tx_valid: load the byte, mosi<=bit7, bit count=0, go to LOW with timer=CLK_DIV. No extra CS_SETUP between bytes.
  - Else if keep_cs=1: remain in GAP indefinitely (cs held, sck low).
  - Else: cs<=0, mosi<=0, go to RELEASE with timer=CS_IDLE.
  - tx_valid takes priority over keep_cs=0 in the same cycle: the transaction continues.
- RELEASE: tx_ready=0. On expiry go to IDLE.
- Latency: from cs rising to rx_valid = CS_SETUP + 15*CLK_DIV clk cycles. With defaults this is 32.
- Edges per byte: exactly 8 rising and 8 falling sck edges. sck is always low when cs changes.
- Ignored input: tx_valid while tx_ready=0 is ignored, not queued. tx_data must be held until accepted.
- keep_cs sampling: keep_cs is sampled only in GAP after timer expiry. Its value during the byte is irrelevant.
- Mid-transfer reset: rst asserted mid-transfer drops cs and sck asynchronously and produces no rx_valid.

Test Plan:
- Single byte, miso looped to mosi, defaults, tx_data=8'hA5, keep_cs=0 -> 8 sck rising edges; mosi bits 1,0,1,0,0,1,0,1; rx_valid 32 cycles after cs rises; rx_data=8'hA5; cs low CS_IDLE cycles before tx_ready=1.
- Two-byte transfer, keep_cs=1 then 0, bytes 8'h3C,8'hC3, miso tied 1 -> cs high continuously across both bytes; two rx_valid pulses, each with rx_data=8'hFF; sck low for >=BYTE_GAP cycles between bytes; 16 rising edges total.
- keep_cs=1 with no further tx_valid for 100 cycles -> cs stays 1, sck stays 0, busy=1. Then keep_cs=0 -> cs falls the next cycle and the block returns to IDLE after CS_IDLE cycles.
- CLK_DIV=1, CS_SETUP=1, byte 8'h81, miso driven 0 -> sck toggles every clk; rx_valid 16 cycles after cs rises; rx_data=8'h00.
- rst pulsed after the 4th sck rising edge of 8'hF0 -> cs=0, sck=0, mosi=0 immediately; no rx_valid pulse; a subsequent 8'h5A transfer completes normally.
- tx_valid held high with changing tx_data during a byte -> only the value present at the tx_ready handshake is shifted out; no extra bytes are sent.

Source files
------------

// File: rtl/spi_master.sv
// Byte-oriented SPI mode 0 initiator with active-high cs, programmable sck rate
// and cs setup / inter-byte gap / idle timing.
module spi_master #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned BYTE_GAP = 4,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       keep_cs,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
);

  localparam int unsigned MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B = (BYTE_GAP > CS_IDLE) ? BYTE_GAP : CS_IDLE;
  localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(MAX_T) + 1;

  // Timer holds remaining cycles minus one, so a state lasts exactly its programmed length.
  localparam logic [TW-1:0] T_DIV   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(BYTE_GAP - 1);
  localparam logic [TW-1:0] T_IDLE  = TW'(CS_IDLE - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_HIGH    = 3'd2;
  localparam logic [2:0] S_LOW     = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          sck_q, sck_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          expired;

  assign expired  = (timer_q == '0);
  assign tx_ready = (state_q == S_IDLE) || ((state_q == S_GAP) && expired);
  assign busy     = (state_q != S_IDLE);
  assign sck      = sck_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // Next-state and datapath decode
  always_comb begin
    state_d    = state_q;
    timer_d    = expired ? timer_q : timer_q - TW'(1);
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_sh_d   = tx_data;
          cs_d      = 1'b1;
          mosi_d    = tx_data[7];
          bit_cnt_d = 3'd0;
          state_d   = S_SETUP;
          timer_d   = T_SETUP;
        end
      end
      S_SETUP: begin
        if (expired) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          state_d = S_HIGH;
          timer_d = T_DIV;
        end
      end
      S_HIGH: begin
        if (expired) begin
          sck_d = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            mosi_d    = tx_sh_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_LOW;
            timer_d   = T_DIV;
          end else begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = S_GAP;
            timer_d    = T_GAP;
          end
        end
      end
      S_LOW: begin
        if (expired) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          state_d = S_HIGH;
          timer_d = T_DIV;
        end
      end
      S_GAP: begin
        // A new byte wins over ending the transaction; keep_cs only matters when none is offered.
        if (expired) begin
          if (tx_valid) begin
            tx_sh_d   = tx_data;
            mosi_d    = tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = S_LOW;
            timer_d   = T_DIV;
          end else if (!keep_cs) begin
            cs_d    = 1'b0;
            mosi_d  = 1'b0;
            state_d = S_RELEASE;
            timer_d = T_IDLE;
          end
        end
      end
      S_RELEASE: begin
        if (expired) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sck_d   = 1'b0;
        cs_d    = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b0;
      mosi_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default-timing instance plus a fastest-timing instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, keep_cs;
  logic [7:0] rx_data;
  logic       rx_valid, busy, sck, mosi, miso, cs;

  logic [7:0] f_tx_data;
  logic       f_tx_valid, f_tx_ready, f_keep_cs;
  logic [7:0] f_rx_data;
  logic       f_rx_valid, f_busy, f_sck, f_mosi, f_miso, f_cs;

  logic       loop;
  logic [7:0] miso_byte;
  int         bit_idx;
  logic [2:0] miso_sel;

  int asserts = 0;
  int fails   = 0;

  spi_master dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .keep_cs(keep_cs), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sck(sck), .mosi(mosi), .miso(miso), .cs(cs)
  );

  spi_master #(.CLK_DIV(1), .CS_SETUP(1), .BYTE_GAP(1), .CS_IDLE(1)) dut_fast (
    .clk(clk), .rst(rst), .tx_data(f_tx_data), .tx_valid(f_tx_valid), .tx_ready(f_tx_ready),
    .keep_cs(f_keep_cs), .rx_data(f_rx_data), .rx_valid(f_rx_valid), .busy(f_busy),
    .sck(f_sck), .mosi(f_mosi), .miso(f_miso), .cs(f_cs)
  );

  // Slave model: either echo mosi, or present miso_byte MSB first, one bit per sck period
  always_comb miso_sel = (bit_idx > 7) ? 3'd0 : 3'(7 - bit_idx);
  assign miso = loop ? mosi : miso_byte[miso_sel];

  // Link monitor, sampled on the falling clk edge
  int   cyc = 0, rises = 0, falls = 0, low_run = 0;
  int   mosi_err = 0, edge_err = 0, cs_rises = 0, cs_falls = 0;
  int   cs_rise_cyc = 0, cs_fall_cyc = 0, idle_cyc = 0, rxv_cyc = 0;
  logic sck_p = 1'b0, cs_p = 1'b0, busy_p = 1'b0, mosi_p = 1'b0;
  logic       mosi_bits[$];
  int         low_runs[$];
  logic [7:0] rx_q[$];

  initial bit_idx = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bit_idx = 0;
      low_run = 0;
    end else begin
      if (sck && !sck_p) begin
        rises++;
        mosi_bits.push_back(mosi);
        low_runs.push_back(low_run);
        low_run = 0;
        bit_idx++;
      end
      if (!sck && sck_p) falls++;
      if (!sck) low_run++;
      if (sck && sck_p && (mosi !== mosi_p)) mosi_err++;
      if ((cs !== cs_p) && (sck || sck_p)) edge_err++;
      if (cs && !cs_p) begin cs_rises++; cs_rise_cyc = cyc; end
      if (!cs && cs_p) begin cs_falls++; cs_fall_cyc = cyc; end
      if (!busy && busy_p) idle_cyc = cyc;
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        rxv_cyc = cyc;
        bit_idx = 0;
      end
    end
    sck_p  = sck;
    cs_p   = cs;
    busy_p = busy;
    mosi_p = mosi;
  end

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mosi_bits[base+i];
    return b;
  endfunction

  task automatic send(input logic [7:0] d, output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    if (!tx_ready) ok = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 2000) begin @(negedge clk); k++; end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int k;
    k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; keep_cs = 1'b0;
    f_tx_valid = 1'b0; f_tx_data = 8'h00; f_keep_cs = 1'b0; f_miso = 1'b0;
    loop = 1'b1; miso_byte = 8'h00;
    repeat (3) @(negedge clk);
    asserts++; if ({sck, cs, mosi} !== 3'b000) begin fails++; $display("FAIL reset_pins: sck/cs/mosi=%b expected 000", {sck, cs, mosi}); end
    asserts++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    asserts++; if ({rx_valid, busy} !== 2'b00) begin fails++; $display("FAIL reset_flags: rx_valid/busy=%b expected 00", {rx_valid, busy}); end
    rst = 1'b0;
    @(negedge clk);
    asserts++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_single_loopback();
    int r0, f0, bb, br, me0, ee0;
    bit ok;
    loop = 1'b1; keep_cs = 1'b0;
    r0 = rises; f0 = falls; bb = mosi_bits.size(); br = rx_q.size(); me0 = mosi_err; ee0 = edge_err;
    send(8'hA5, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL single_accept: tx_ready never seen"); end
    wait_rx(br + 1, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL single_rx_timeout: no rx_valid"); end
    wait_idle(ok);
    repeat (4) @(negedge clk);
    asserts++; if (rises - r0 != 8) begin fails++; $display("FAIL single_rises: got %0d expected 8", rises - r0); end
    asserts++; if (falls - f0 != 8) begin fails++; $display("FAIL single_falls: got %0d expected 8", falls - f0); end
    if (mosi_bits.size() >= bb + 8) begin
      asserts++; if (get_byte(bb) !== 8'hA5) begin fails++; $display("FAIL single_mosi: got %h expected a5", get_byte(bb)); end
    end
    asserts++; if (rxv_cyc - cs_rise_cyc != 32) begin fails++; $display("FAIL single_latency: got %0d expected 32", rxv_cyc - cs_rise_cyc); end
    asserts++; if (rx_q.size() != br + 1) begin fails++; $display("FAIL single_rx_count: got %0d expected 1", rx_q.size() - br); end
    else begin
      asserts++; if (rx_q[br] !== 8'hA5) begin fails++; $display("FAIL single_rx_data: got %h expected a5", rx_q[br]); end
    end
    asserts++; if (idle_cyc - cs_fall_cyc != 2) begin fails++; $display("FAIL single_cs_idle: got %0d expected 2", idle_cyc - cs_fall_cyc); end
    asserts++; if (mosi_err != me0) begin fails++; $display("FAIL single_mosi_stable: %0d changes while sck high, expected 0", mosi_err - me0); end
    asserts++; if (edge_err != ee0) begin fails++; $display("FAIL single_cs_edge: %0d cs edges with sck high, expected 0", edge_err - ee0); end
  endtask

  task automatic test_two_byte();
    int r0, bb, br, cr0, cf0;
    bit ok1, ok2, ok;
    loop = 1'b0; miso_byte = 8'hFF; keep_cs = 1'b1;
    r0 = rises; bb = mosi_bits.size(); br = rx_q.size(); cr0 = cs_rises; cf0 = cs_falls;
    send(8'h3C, ok1);
    send(8'hC3, ok2);
    keep_cs = 1'b0;
    asserts++; if (!(ok1 && ok2)) begin fails++; $display("FAIL two_accept: ok=%b%b expected 11", ok1, ok2); end
    wait_rx(br + 2, ok);
    wait_idle(ok);
    repeat (4) @(negedge clk);
    asserts++; if (rises - r0 != 16) begin fails++; $display("FAIL two_rises: got %0d expected 16", rises - r0); end
    asserts++; if ((cs_rises - cr0 != 1) || (cs_falls - cf0 != 1)) begin fails++; $display("FAIL two_cs_held: rises %0d falls %0d expected 1 1", cs_rises - cr0, cs_falls - cf0); end
    asserts++; if (rx_q.size() != br + 2) begin fails++; $display("FAIL two_rx_count: got %0d expected 2", rx_q.size() - br); end
    else begin
      asserts++; if ({rx_q[br], rx_q[br+1]} !== 16'hFFFF) begin fails++; $display("FAIL two_rx_data: got %h %h expected ff ff", rx_q[br], rx_q[br+1]); end
    end
    if (mosi_bits.size() >= bb + 16) begin
      asserts++; if ({get_byte(bb), get_byte(bb + 8)} !== 16'h3CC3) begin fails++; $display("FAIL two_mosi: got %h %h expected 3c c3", get_byte(bb), get_byte(bb + 8)); end
      asserts++; if (low_runs[bb+8] < 4) begin fails++; $display("FAIL two_gap: sck low %0d cycles expected >= 4", low_runs[bb+8]); end
    end
  endtask

  task automatic test_keep_hold();
    int br, bad;
    bit ok;
    loop = 1'b1; keep_cs = 1'b1;
    br = rx_q.size();
    send(8'h66, ok);
    wait_rx(br + 1, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL hold_rx_timeout: no rx_valid"); end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b1) bad++;
    end
    asserts++; if (bad != 0) begin fails++; $display("FAIL hold_cs: %0d bad cycles expected 0", bad); end
    keep_cs = 1'b0;
    @(negedge clk);
    asserts++; if ({cs, busy} !== 2'b01) begin fails++; $display("FAIL hold_release: cs/busy=%b expected 01", {cs, busy}); end
    @(negedge clk);
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_idle_early: busy=%b expected 1", busy); end
    @(negedge clk);
    asserts++; if ({busy, tx_ready} !== 2'b01) begin fails++; $display("FAIL hold_idle: busy/tx_ready=%b expected 01", {busy, tx_ready}); end
  endtask

  task automatic test_random();
    logic [7:0] d, mb;
    int bb, br;
    bit ok;
    loop = 1'b0; keep_cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      mb = 8'($urandom);
      miso_byte = mb;
      bb = mosi_bits.size(); br = rx_q.size();
      send(d, ok);
      wait_rx(br + 1, ok);
      wait_idle(ok);
      asserts++;
      if (rx_q.size() != br + 1) begin fails++; $display("FAIL rand_rx_count[%0d]: got %0d expected 1", i, rx_q.size() - br); end
      else if (rx_q[br] !== mb) begin fails++; $display("FAIL rand_rx[%0d]: got %h expected %h", i, rx_q[br], mb); end
      asserts++;
      if (mosi_bits.size() < bb + 8) begin fails++; $display("FAIL rand_mosi_count[%0d]: got %0d bits expected 8", i, mosi_bits.size() - bb); end
      else if (get_byte(bb) !== d) begin fails++; $display("FAIL rand_mosi[%0d]: got %h expected %h", i, get_byte(bb), d); end
    end
  endtask

  task automatic test_reset_mid();
    int r0, br, bb, k;
    bit ok;
    loop = 1'b1; keep_cs = 1'b0;
    r0 = rises; br = rx_q.size();
    send(8'hF0, ok);
    k = 0;
    while (rises - r0 < 4 && k < 500) begin @(negedge clk); k++; end
    asserts++; if (rises - r0 < 4) begin fails++; $display("FAIL mid_rises: got %0d expected 4", rises - r0); end
    #1 rst = 1'b1;
    #1;
    asserts++; if ({cs, sck, mosi, busy} !== 4'b0000) begin fails++; $display("FAIL mid_reset_pins: cs/sck/mosi/busy=%b expected 0000", {cs, sck, mosi, busy}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    asserts++; if (rx_q.size() != br) begin fails++; $display("FAIL mid_no_rx: %0d rx_valid pulses expected 0", rx_q.size() - br); end
    bb = mosi_bits.size();
    send(8'h5A, ok);
    wait_rx(br + 1, ok);
    wait_idle(ok);
    asserts++;
    if (rx_q.size() != br + 1) begin fails++; $display("FAIL mid_after_count: got %0d expected 1", rx_q.size() - br); end
    else if (rx_q[br] !== 8'h5A) begin fails++; $display("FAIL mid_after_rx: got %h expected 5a", rx_q[br]); end
    asserts++;
    if (mosi_bits.size() != bb + 8) begin fails++; $display("FAIL mid_after_bits: got %0d expected 8", mosi_bits.size() - bb); end
    else if (get_byte(bb) !== 8'h5A) begin fails++; $display("FAIL mid_after_mosi: got %h expected 5a", get_byte(bb)); end
  endtask

  task automatic test_hold_valid();
    logic [7:0] d0;
    int r0, bb, br, k;
    bit ok;
    loop = 1'b1; keep_cs = 1'b0;
    d0 = 8'($urandom);
    r0 = rises; bb = mosi_bits.size(); br = rx_q.size();
    @(negedge clk);
    tx_data = d0; tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 100) begin @(negedge clk); k++; end
    k = 0;
    do begin
      @(negedge clk);
      tx_data = 8'($urandom);
      k++;
    end while (rx_q.size() == br && k < 500);
    tx_valid = 1'b0;
    wait_idle(ok);
    repeat (10) @(negedge clk);
    asserts++; if (rises - r0 != 8) begin fails++; $display("FAIL holdv_rises: got %0d expected 8", rises - r0); end
    asserts++;
    if (rx_q.size() != br + 1) begin fails++; $display("FAIL holdv_rx_count: got %0d expected 1", rx_q.size() - br); end
    else if (rx_q[br] !== d0) begin fails++; $display("FAIL holdv_rx: got %h expected %h", rx_q[br], d0); end
    asserts++;
    if (mosi_bits.size() < bb + 8) begin fails++; $display("FAIL holdv_bits: got %0d expected 8", mosi_bits.size() - bb); end
    else if (get_byte(bb) !== d0) begin fails++; $display("FAIL holdv_mosi: got %h expected %h", get_byte(bb), d0); end
  endtask

  task automatic test_fast();
    int k, fr, ff, rxk, stuck;
    logic prev, started;
    logic [7:0] sent;
    f_miso = 1'b0;
    @(negedge clk);
    asserts++; if (f_tx_ready !== 1'b1) begin fails++; $display("FAIL fast_ready: got %b expected 1", f_tx_ready); end
    f_tx_data = 8'h81; f_tx_valid = 1'b1;
    @(negedge clk);
    f_tx_valid = 1'b0;
    asserts++; if (f_cs !== 1'b1) begin fails++; $display("FAIL fast_cs: got %b expected 1", f_cs); end
    fr = 0; ff = 0; rxk = -1; stuck = 0; started = 1'b0; prev = f_sck; sent = 8'h00;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (started && ff < 8 && f_sck === prev) stuck++;
      if (f_sck && !prev) begin
        if (fr < 8) sent[3'(7 - fr)] = f_mosi;
        fr++;
        started = 1'b1;
      end
      if (!f_sck && prev) ff++;
      if (f_rx_valid && rxk < 0) rxk = k;
      prev = f_sck;
    end
    asserts++; if (fr != 8 || ff != 8) begin fails++; $display("FAIL fast_edges: rises %0d falls %0d expected 8 8", fr, ff); end
    asserts++; if (rxk != 16) begin fails++; $display("FAIL fast_latency: got %0d expected 16", rxk); end
    asserts++; if (f_rx_data !== 8'h00) begin fails++; $display("FAIL fast_rx: got %h expected 00", f_rx_data); end
    asserts++; if (stuck != 0) begin fails++; $display("FAIL fast_toggle: %0d non-toggling cycles expected 0", stuck); end
    asserts++; if (sent !== 8'h81) begin fails++; $display("FAIL fast_mosi: got %h expected 81", sent); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_loopback();
    test_two_byte();
    test_keep_hold();
    test_random();
    test_reset_mid();
    test_hold_valid();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
